// File: rtl/rect_compositor.sv
// rtl/rect_compositor.sv - rectangle overlay compositor with shadowed registers, blink and a 2-stage RGB565 pipeline
// Lowest-index enabled rectangle covering the pixel wins; otherwise the background colour is shown.
module rect_compositor #(
  parameter int NUM_RECTS    = 4,
  parameter int COORD_W      = 16,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                              PixelClk,
  input  logic                              Reset,
  input  logic [COORD_W-1:0]                PixelCount,
  input  logic [COORD_W-1:0]                LineCount,
  input  logic                              DeIn,
  input  logic                              FrameSync,
  input  logic                              WrEn,
  input  logic [$clog2(NUM_RECTS+1)+2:0]    WrAddr,
  input  logic [15:0]                       WrData,
  output logic [4:0]                        LCD_R,
  output logic [5:0]                        LCD_G,
  output logic [4:0]                        LCD_B,
  output logic                              DeOut
);

  localparam int IW = $clog2(NUM_RECTS+1);
  localparam int CW = $clog2(BLINK_FRAMES+1);

  logic [IW-1:0] wr_idx;
  logic [2:0]    wr_fld;
  assign wr_idx = WrAddr[IW+2:3];
  assign wr_fld = WrAddr[2:0];

  logic [COORD_W-1:0]   sh_x0_q [NUM_RECTS];
  logic [COORD_W-1:0]   sh_x1_q [NUM_RECTS];
  logic [COORD_W-1:0]   sh_y0_q [NUM_RECTS];
  logic [COORD_W-1:0]   sh_y1_q [NUM_RECTS];
  logic [15:0]          sh_col_q [NUM_RECTS];
  logic [NUM_RECTS-1:0] sh_en_q, sh_blink_q;
  logic [15:0]          sh_bg_q;

  logic [COORD_W-1:0]   act_x0_q [NUM_RECTS];
  logic [COORD_W-1:0]   act_x1_q [NUM_RECTS];
  logic [COORD_W-1:0]   act_y0_q [NUM_RECTS];
  logic [COORD_W-1:0]   act_y1_q [NUM_RECTS];
  logic [15:0]          act_col_q [NUM_RECTS];
  logic [NUM_RECTS-1:0] act_en_q, act_blink_q;
  logic [15:0]          act_bg_q;

  logic [CW-1:0]        blink_cnt_q;
  logic                 blink_phase_q;

  logic [NUM_RECTS-1:0] hit_d, hit_q;
  logic                 de1_q;
  logic [15:0]          rgb_d, rgb_q;
  logic                 de_out_q;

  // Active copy takes the pre-write shadow value when a write coincides with FrameSync.
  always_ff @(posedge PixelClk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_RECTS; i++) begin
        sh_x0_q[i]   <= '0;
        sh_x1_q[i]   <= '0;
        sh_y0_q[i]   <= '0;
        sh_y1_q[i]   <= '0;
        sh_col_q[i]  <= '0;
        act_x0_q[i]  <= '0;
        act_x1_q[i]  <= '0;
        act_y0_q[i]  <= '0;
        act_y1_q[i]  <= '0;
        act_col_q[i] <= '0;
      end
      sh_en_q     <= '0;
      sh_blink_q  <= '0;
      act_en_q    <= '0;
      act_blink_q <= '0;
      sh_bg_q     <= '0;
      act_bg_q    <= '0;
    end else begin
      if (FrameSync) begin
        for (int i = 0; i < NUM_RECTS; i++) begin
          act_x0_q[i]  <= sh_x0_q[i];
          act_x1_q[i]  <= sh_x1_q[i];
          act_y0_q[i]  <= sh_y0_q[i];
          act_y1_q[i]  <= sh_y1_q[i];
          act_col_q[i] <= sh_col_q[i];
        end
        act_en_q    <= sh_en_q;
        act_blink_q <= sh_blink_q;
        act_bg_q    <= sh_bg_q;
      end
      if (WrEn) begin
        for (int i = 0; i < NUM_RECTS; i++) begin
          if (wr_idx == IW'(i)) begin
            case (wr_fld)
              3'd0: sh_x0_q[i]  <= WrData[COORD_W-1:0];
              3'd1: sh_x1_q[i]  <= WrData[COORD_W-1:0];
              3'd2: sh_y0_q[i]  <= WrData[COORD_W-1:0];
              3'd3: sh_y1_q[i]  <= WrData[COORD_W-1:0];
              3'd4: sh_col_q[i] <= WrData;
              3'd5: begin
                sh_en_q[i]    <= WrData[0];
                sh_blink_q[i] <= WrData[1];
              end
              default: ;
            endcase
          end
        end
        if (wr_idx == IW'(NUM_RECTS) && wr_fld == 3'd0) sh_bg_q <= WrData;
      end
    end
  end

  always_ff @(posedge PixelClk) begin
    if (Reset) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (FrameSync) begin
      if (blink_cnt_q == CW'(BLINK_FRAMES-1)) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    hit_d = '0;
    for (int i = 0; i < NUM_RECTS; i++) begin
      hit_d[i] = act_en_q[i] && !(act_blink_q[i] && blink_phase_q) &&
                 (PixelCount >= act_x0_q[i]) && (PixelCount < act_x1_q[i]) &&
                 (LineCount  >= act_y0_q[i]) && (LineCount  < act_y1_q[i]);
    end
  end

  // Scan from the top index down so the lowest-index hit overwrites last.
  always_comb begin
    rgb_d = act_bg_q;
    for (int i = NUM_RECTS-1; i >= 0; i--) begin
      if (hit_q[i]) rgb_d = act_col_q[i];
    end
    if (!de1_q) rgb_d = '0;
  end

  always_ff @(posedge PixelClk) begin
    if (Reset) begin
      hit_q    <= '0;
      de1_q    <= 1'b0;
      rgb_q    <= '0;
      de_out_q <= 1'b0;
    end else begin
      hit_q    <= hit_d;
      de1_q    <= DeIn;
      rgb_q    <= rgb_d;
      de_out_q <= de1_q;
    end
  end

  assign LCD_R = rgb_q[15:11];
  assign LCD_G = rgb_q[10:5];
  assign LCD_B = rgb_q[4:0];
  assign DeOut = de_out_q;

endmodule

// File: tb/tb_rect_compositor.sv
// tb/tb_rect_compositor.sv - self-checking bench for rect_compositor
module tb_rect_compositor;

  localparam int NR = 4;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] px_in, ly_in;
  logic        de_in, fs_in, we_in;
  logic [5:0]  wa_in;
  logic [15:0] wd_in;
  logic [4:0]  lcd_r;
  logic [5:0]  lcd_g;
  logic [4:0]  lcd_b;
  logic        de_out;

  int checks = 0;
  int errors = 0;

  rect_compositor #(.NUM_RECTS(NR), .COORD_W(16), .BLINK_FRAMES(BF)) dut (
    .PixelClk(clk), .Reset(rst), .PixelCount(px_in), .LineCount(ly_in),
    .DeIn(de_in), .FrameSync(fs_in), .WrEn(we_in), .WrAddr(wa_in), .WrData(wd_in),
    .LCD_R(lcd_r), .LCD_G(lcd_g), .LCD_B(lcd_b), .DeOut(de_out)
  );

  always #5 clk = ~clk;

  // Reference model: register file, frame-sync count and per-pixel rule.
  int sh_c [NR][4];
  int ac_c [NR][4];
  int sh_col [NR], ac_col [NR], sh_ctl [NR], ac_ctl [NR];
  int sh_bg, ac_bg, syncs;
  logic [16:0] prev_exp;

  function automatic logic [16:0] outv();
    return {de_out, lcd_r, lcd_g, lcd_b};
  endfunction

  task automatic check(input string nm, input logic [16:0] got, input logic [16:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      for (int k = 0; k < 4; k++) begin
        sh_c[r][k] = 0;
        ac_c[r][k] = 0;
      end
      sh_col[r] = 0; ac_col[r] = 0; sh_ctl[r] = 0; ac_ctl[r] = 0;
    end
    sh_bg = 0; ac_bg = 0; syncs = 0;
  endtask

  task automatic model_clock(input bit fs, input bit we, input int a, input int d);
    int idx, f;
    if (fs) begin
      ac_c = sh_c; ac_col = sh_col; ac_ctl = sh_ctl; ac_bg = sh_bg;
      syncs++;
    end
    if (we) begin
      idx = a >> 3;
      f   = a & 7;
      if (idx < NR) begin
        if (f < 4) sh_c[idx][f] = d & 'hFFFF;
        else if (f == 4) sh_col[idx] = d & 'hFFFF;
        else if (f == 5) sh_ctl[idx] = d & 3;
      end else if (idx == NR && f == 0) begin
        sh_bg = d & 'hFFFF;
      end
    end
  endtask

  function automatic logic [16:0] model_pix(input int px, input int ly, input bit de);
    bit hidden_phase;
    hidden_phase = ((syncs / BF) % 2) == 1;
    if (!de) return 17'h0;
    for (int r = 0; r < NR; r++) begin
      if ((ac_ctl[r] & 1) != 0 && !(hidden_phase && (ac_ctl[r] & 2) != 0) &&
          px >= ac_c[r][0] && px < ac_c[r][1] && ly >= ac_c[r][2] && ly < ac_c[r][3])
        return {1'b1, 16'(ac_col[r])};
    end
    return {1'b1, 16'(ac_bg)};
  endfunction

  task automatic cyc(input int px, input int ly, input bit de, input bit fs,
                     input bit we, input int wa, input int wd, input bit r);
    logic [16:0] e, now_exp;
    @(negedge clk);
    px_in = 16'(px); ly_in = 16'(ly); de_in = de; fs_in = fs;
    we_in = we; wa_in = 6'(wa); wd_in = 16'(wd); rst = r;
    e = r ? 17'h0 : model_pix(px, ly, de);
    @(posedge clk);
    if (r) model_reset();
    else model_clock(fs, we, wa, wd);
    now_exp  = r ? 17'h0 : prev_exp;
    prev_exp = e;
    #1;
    check("pipe", outv(), now_exp);
  endtask

  task automatic wr(input int idx, input int f, input int d);
    cyc(0, 0, 1'b0, 1'b0, 1'b1, idx * 8 + f, d, 1'b0);
  endtask

  task automatic pix(input int x, input int y, input bit de);
    cyc(x, y, de, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic fsync();
    cyc(0, 0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic do_reset();
    cyc(0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    cyc(0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
  endtask

  task automatic rect(input int i, input int x0, input int x1, input int y0, input int y1,
                      input int col, input int ctl);
    wr(i, 0, x0); wr(i, 1, x1); wr(i, 2, y0); wr(i, 3, y1); wr(i, 4, col); wr(i, 5, ctl);
  endtask

  typedef struct {
    int          px;
    int          ly;
    bit          de;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{100, 200, 1'b1, 17'h15568};
    tbl[1] = '{400, 200, 1'b1, 17'h11234};
    tbl[2] = '{399, 399, 1'b1, 17'h15568};
    tbl[3] = '{ 99, 250, 1'b1, 17'h11234};
    tbl[4] = '{150, 250, 1'b1, 17'h15568};
    tbl[5] = '{ 50,  10, 1'b1, 17'h11234};
    tbl[6] = '{150, 250, 1'b0, 17'h00000};
    tbl[7] = '{200, 400, 1'b1, 17'h11234};
    tbl[8] = '{  0,   0, 1'b1, 17'h11234};

    prev_exp = 17'h0;
    rst = 1'b1; px_in = '0; ly_in = '0; de_in = 1'b0; fs_in = 1'b0;
    we_in = 1'b0; wa_in = '0; wd_in = '0;
    model_reset();
    do_reset();
    check("reset_state", outv(), 17'h0);

    rect(0, 100, 400, 200, 400, 'h5568, 1);
    rect(1, 120, 300, 230, 300, 'h001F, 1);
    rect(2, 50, 50, 0, 1000, 'h07E0, 1);
    wr(NR, 0, 'h1234);
    pix(100, 200, 1'b1); pix(0, 0, 1'b0);
    check("before_sync_shadow_only", outv(), 17'h10000);
    fsync();

    for (int i = 0; i < 9; i++) begin
      pix(tbl[i].px, tbl[i].ly, tbl[i].de);
      pix(0, 0, 1'b0);
      check($sformatf("vec%0d", i), outv(), tbl[i].exp);
    end

    wr(0, 4, 'hF800);
    pix(150, 250, 1'b1); pix(0, 0, 1'b0);
    check("shadow_old_colour", outv(), 17'h15568);
    fsync();
    pix(150, 250, 1'b1); pix(0, 0, 1'b0);
    check("priority_red", outv(), 17'h1F800);
    cyc(0, 0, 1'b0, 1'b1, 1'b1, 4, 'h07E0, 1'b0);
    pix(150, 250, 1'b1); pix(0, 0, 1'b0);
    check("write_at_sync_deferred", outv(), 17'h1F800);
    fsync();
    pix(150, 250, 1'b1); pix(0, 0, 1'b0);
    check("write_at_sync_applied", outv(), 17'h107E0);

    pix(150, 250, 1'b1);
    cyc(150, 250, 1'b1, 1'b1, 1'b1, 4, 'hFFFF, 1'b1);
    check("midframe_reset_zero", outv(), 17'h0);
    pix(150, 250, 1'b1); pix(150, 250, 1'b1);
    check("after_reset_bg0", outv(), 17'h10000);
    fsync();
    pix(150, 250, 1'b1); pix(0, 0, 1'b0);
    check("reset_overrides_write", outv(), 17'h10000);

    do_reset();
    rect(0, 0, 10, 0, 10, 'hFFFF, 3);
    for (int n = 1; n <= 5; n++) begin
      fsync();
      pix(5, 5, 1'b1); pix(0, 0, 1'b0);
      check($sformatf("blink_frame%0d", n), outv(),
            (n == 1 || n == 4 || n == 5) ? 17'h1FFFF : 17'h10000);
    end

    do_reset();
    for (int f = 0; f < 8; f++) begin
      for (int c = 0; c < 60; c++) begin
        int a, d;
        a = $urandom_range(0, 63);
        d = ((a & 7) < 4) ? $urandom_range(0, 255) : ($urandom & 'hFFFF);
        cyc($urandom_range(0, 255), $urandom_range(0, 255), ($urandom % 4) != 0,
            1'b0, ($urandom % 3) == 0, a, d, 1'b0);
      end
      cyc(0, 0, 1'b0, 1'b1, $urandom % 2, $urandom_range(0, 63), $urandom_range(0, 255), 1'b0);
    end
    pix(0, 0, 1'b0); pix(0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rect_compositor.md
RECT_COMPOSITOR -- requirements
Module: rect_compositor

Interface
REQ-001 SHALL have parameter NUM_RECTS, default 4, meaning the number of programmable rectangles (1..8).
REQ-002 SHALL have parameter COORD_W, default 16, meaning the width of the coordinates and of PixelCount/LineCount.
REQ-003 SHALL have parameter BLINK_FRAMES, default 30, meaning the frames per blink half-period (>=1).
REQ-004 SHALL have port PixelClk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port PixelCount, input, COORD_W bits: current pixel X.
REQ-007 SHALL have port LineCount, input, COORD_W bits: current line Y.
REQ-008 SHALL have port DeIn, input, 1 bit: the pixel is in the active area.
REQ-009 SHALL have port FrameSync, input, 1 bit: one-cycle pulse at frame start.
REQ-010 SHALL have port WrEn, input, 1 bit: register write strobe.
REQ-011 SHALL have port WrAddr, input, $clog2(NUM_RECTS+1)+3 bits, laid out as {index, field[2:0]}.
REQ-012 SHALL have port WrData, input, 16 bits: write data.
REQ-013 SHALL have ports LCD_R (5 bits), LCD_G (6 bits) and LCD_B (5 bits), outputs: registered RGB565 pixel.
REQ-014 SHALL have port DeOut, output, 1 bit: DeIn delayed to align with the LCD_* outputs.

Function
REQ-015 SHALL map writes for index<NUM_RECTS by field: 0=X0, 1=X1, 2=Y0, 3=Y1, 4=colour RGB565 {R[15:11],G[10:5],B[4:0]}, 5=ctrl {bit0 enable, bit1 blink}; 6-7 ignored.
REQ-016 SHALL map writes for index==NUM_RECTS as: field 0=background colour; other fields ignored; larger index ignored.
REQ-017 SHALL apply writes to shadow registers on the cycle WrEn=1; coordinates use WrData[COORD_W-1:0].
REQ-018 SHALL copy all shadow registers to active registers on the cycle FrameSync=1; the pixel path uses only active registers.
REQ-019 SHALL land a write coincident with FrameSync in shadow only; active takes the pre-write shadow value; the write becomes visible at the next FrameSync.
REQ-020 SHALL treat rectangle i as hit when enabled, X0<=PixelCount<X1 and Y0<=LineCount<Y1 (unsigned); X0>=X1 or Y0>=Y1 never hits.
REQ-021 SHALL suppress the hit of a rectangle with blink=1 while BlinkPhase=1.
REQ-022 SHALL hold an internal BlinkCnt that increments on FrameSync, wraps BLINK_FRAMES-1 -> 0, and toggles BlinkPhase on the wrap.
REQ-023 SHALL let the lowest-index hit rectangle win; no hit selects background.
REQ-024 SHALL use stage 1 to register the per-rect hit vector and DeIn; stage 2 registers the selected colour and DeOut; latency is exactly 2 PixelClk cycles.
REQ-025 SHALL drive LCD_R/G/B to 0 whenever the aligned DeOut=0.
REQ-026 SHALL advance the pipeline every cycle, with no stall or backpressure; FrameSync does not flush in-flight pixels.

Reset
REQ-027 SHALL on Reset=1 clear all shadow and active registers (coords 0, colours 0, enable/blink 0, background 0).
REQ-028 SHALL on Reset=1 clear BlinkCnt, BlinkPhase, pipeline valids, DeOut and LCD_R/G/B to 0, visible on the next edge.
REQ-029 SHALL on Reset=1 mid-frame give outputs 0 from the next cycle until 2 cycles after reset deasserts with DeIn=1; Reset overrides coincident WrEn and FrameSync.

Verification
REQ-030 SHALL be verified for a basic hit: rect0 = X 100..400, Y 200..400, colour 0x5568, enabled, FrameSync; pixel (100,200) DeIn=1 -> 2 cycles later LCD_G=0x2B, LCD_B=0x08, DeOut=1; pixel (400,200) -> background.
REQ-031 SHALL be verified for priority: rect0 and rect1 overlap at (150,250), rect0=0xF800, rect1=0x001F -> output R=0x1F, G=0, B=0.
REQ-032 SHALL be verified for shadowing: rewrite rect0 colour mid-frame -> old colour until the next FrameSync; write coincident with FrameSync -> applied one frame later.
REQ-033 SHALL be verified for blink: BLINK_FRAMES=2, rect blink=1 -> visible frames 0-1, hidden frames 2-3, visible 4-5.
REQ-034 SHALL be verified for degenerate rects and blanking: X0=X1=50 -> never hit; DeIn=0 inside a rect -> RGB=0, DeOut=0.
REQ-035 SHALL be verified for mid-frame reset: Reset while drawing -> next cycle RGB=0; after release with no FrameSync, everything shows background 0.
